// File: rtl/ace_arith_pkg.sv
// Shared arithmetic-unit types and constants for the sequential divider.
package ace_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Wide enough for any WIDTH; users slice [WIDTH-1:0].
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  // Step-counter width for an arbitrary WIDTH (never zero bits).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic             shreg_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] dvsr_ext;

  always_comb begin
    p_shift  = (p << 1) | {{WIDTH{1'b0}}, shreg_msb};
    dvsr_ext = {1'b0, divisor};
    // No borrow from P' - divisor is the same as P' >= divisor.
    q_bit    = (p_shift >= dvsr_ext);
    p_next   = q_bit ? (p_shift - dvsr_ext) : p_shift;
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider with start/done handshake, one bit per clock.
// Define DIV_SIGNED_EN to add the signed_mode input (truncating signed divide).
//
// state | meaning
// IDLE  | ready; results held; start accepted here only
// CALC  | one shift / trial-subtract step per edge, WIDTH steps
// DONE  | done pulse for one cycle, then back to IDLE
module div_seq
  import ace_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH:0]   p_next;
  logic [CW-1:0]    cnt;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             neg_q;
  logic             neg_r;

`ifdef DIV_SIGNED_EN
  always_comb begin
    a_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= signed_mode & dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign neg_q = 1'b0;
  assign neg_r = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .p         (p_reg),
    .shreg_msb (shreg[WIDTH-1]),
    .divisor   (dvsr),
    .p_next    (p_next),
    .q_bit     (q_bit)
  );

  // Final-edge results, including the last step's bit and the sign fix-up.
  always_comb begin
    q_raw   = {shreg[WIDTH-2:0], q_bit};
    r_raw   = p_next[WIDTH-1:0];
    q_final = neg_q ? -q_raw : q_raw;
    r_final = neg_r ? -r_raw : r_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      dvsr        <= '0;
      p_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= a_mag;
            dvsr  <= b_mag;
            p_reg <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          p_reg <= p_next;
          shreg <= {shreg[WIDTH-2:0], q_bit};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model plus directed vectors.
module tb_div_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         sm_drv = 1'b0;
  logic         ready, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_mode (sm_drv),
`endif
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer divide, truncating toward zero when signed.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Transaction-level model: an op occupies a fixed number of cycles after accept.
  logic [W-1:0] pq = '0, pr = '0, sq = '0, sr = '0;
  logic         pz = 1'b0, sz = 1'b0;
  bit           inflight = 1'b0;
  int           left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight = 1'b0; left = 0;
      sq = '0; sr = '0; sz = 1'b0;
    end else if (inflight) begin
      if (left == 0) inflight = 1'b0;
      else left--;
      if (inflight && left == 0) begin sq = pq; sr = pr; sz = pz; end
    end else if (start) begin
      ref_div(dividend, divisor, sm_drv, pq, pr, pz);
      inflight = 1'b1;
      left = (divisor == '0) ? 0 : W;
      if (left == 0) begin sq = pq; sr = pr; sz = pz; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", ready, !inflight);
      check("m_busy", busy, inflight);
      check("m_done", done, inflight && left == 0);
      check("m_quot", quotient, sq);
      check("m_rem", remainder, sr);
      check("m_dbz", div_by_zero, sz);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin @(posedge clk); #1; n++; end
    check("wait_ready", ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int elat, input string nm);
    int lat;
    wait_ready();
    dividend = a; divisor = b; sm_drv = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom); sm_drv = 1'($urandom);
    check({nm, "_busy1"}, busy, 1);
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check({nm, "_lat"}, lat, elat);
    check({nm, "_q"}, quotient, eq);
    check({nm, "_r"}, remainder, er);
    check({nm, "_dbz"}, div_by_zero, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dn;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_q", quotient, 0);
    check("rst_dbz", div_by_zero, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, W + 1, "d100_7");
    @(posedge clk); #1;
    check("d100_7_ready10", ready, 1);
    check("d100_7_busy10", busy, 0);

    run_op(8'd7, 8'd100, 1'b0, 8'd0, 8'd7, 1'b0, W + 1, "d7_100");
    run_op(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, W + 1, "d255_1");
    run_op(8'd200, 8'd201, 1'b0, 8'd0, 8'd200, 1'b0, W + 1, "d200_201");
    run_op(8'd0, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0, W + 1, "d0_5");
    run_op(8'd255, 8'd200, 1'b0, 8'd1, 8'd55, 1'b0, W + 1, "d255_200");
    run_op(8'd42, 8'd0, 1'b0, 8'hFF, 8'd42, 1'b1, 1, "d42_0");
    run_op(8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, W + 1, "d9_3");

    // Re-pulsed start during CALC must be ignored.
    wait_ready();
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check("ignore_done_seen", done, 1);
    check("ignore_q", quotient, 14);
    check("ignore_r", remainder, 2);

    // Reset in cycle 4 of a new op: immediate clear, no done pulse.
    wait_ready();
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    dn = 0;
    repeat (12) begin @(posedge clk); #1; if (done) dn++; end
    check("midrst_no_done", dn, 0);

    // start held high re-launches on each return to IDLE.
    wait_ready();
    dividend = 8'd20; divisor = 8'd3; start = 1'b1;
    dn = 0;
    repeat (2 * (W + 2)) begin @(posedge clk); #1; if (done) dn++; end
    start = 1'b0;
    check("held_start_dones", dn, 2);
    check("held_start_q", quotient, 6);
    check("held_start_r", remainder, 2);

`ifdef DIV_SIGNED_EN
    run_op(8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0, W + 1, "s_m100_7");
    run_op(8'd100, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, W + 1, "s_100_m7");
    run_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, W + 1, "s_m128_m1");
    run_op(8'h9C, 8'd0, 1'b1, 8'hFF, 8'h9C, 1'b1, 1, "s_dbz");
`endif

    wait_ready();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
